// File: rtl/instruction_profiler_pkg.sv
// Shared MIPS opcode/funct codes and profiler class indices.
package instruction_profiler_pkg;

  localparam int NUM_CLASSES  = 9;
  localparam int NUM_COUNTERS = NUM_CLASSES + 1;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JUMP    = 4'd5,
    CLS_SYSCALL = 4'd6,
    CLS_MULDIV  = 4'd7,
    CLS_UNKNOWN = 4'd8,
    CLS_TOTAL   = 4'd9
  } inst_class_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LB    = 6'd32;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FUNCT_SLL     = 6'd0;
  localparam logic [5:0] FUNCT_SRL     = 6'd2;
  localparam logic [5:0] FUNCT_SRA     = 6'd3;
  localparam logic [5:0] FUNCT_JR      = 6'd8;
  localparam logic [5:0] FUNCT_SYSCALL = 6'd12;
  localparam logic [5:0] FUNCT_MFLO    = 6'd18;
  localparam logic [5:0] FUNCT_DIVU    = 6'd27;
  localparam logic [5:0] FUNCT_ADD     = 6'd32;
  localparam logic [5:0] FUNCT_ADDU    = 6'd33;
  localparam logic [5:0] FUNCT_SUB     = 6'd34;
  localparam logic [5:0] FUNCT_AND     = 6'd36;
  localparam logic [5:0] FUNCT_OR      = 6'd37;
  localparam logic [5:0] FUNCT_NOR     = 6'd39;
  localparam logic [5:0] FUNCT_SLT     = 6'd42;
  localparam logic [5:0] FUNCT_SLTU    = 6'd43;

endpackage

// File: rtl/instruction_profiler_classifier.sv
// Combinational decoder mapping a MIPS op/funct pair onto a profiler class index.
module inst_classifier
  import instruction_profiler_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] cls
);

  // R-type words are split by funct; all other words are classified by opcode alone
  always_comb begin
    cls = CLS_UNKNOWN;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_NOR,
          FUNCT_SLT, FUNCT_SLTU, FUNCT_SLL, FUNCT_SRL, FUNCT_SRA:
            cls = CLS_ALU_R;
          FUNCT_JR:
            cls = CLS_JUMP;
          FUNCT_SYSCALL:
            cls = CLS_SYSCALL;
          FUNCT_DIVU, FUNCT_MFLO:
            cls = CLS_MULDIV;
          default:
            cls = CLS_UNKNOWN;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: cls = CLS_ALU_I;
      OP_LW, OP_LB:                                cls = CLS_LOAD;
      OP_SW:                                       cls = CLS_STORE;
      OP_BEQ, OP_BNE, OP_BGTZ:                     cls = CLS_BRANCH;
      OP_J, OP_JAL:                                cls = CLS_JUMP;
      default:                                     cls = CLS_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/instruction_profiler.sv
// Two-stage retired-instruction profiler: classify and register, then bump the
// class counter plus TOTAL. Counters saturate; a SYSCALL can freeze capture.
module instruction_profiler
  import instruction_profiler_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_SYSCALL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [31:0]      inst,
  input  logic             clr,
  input  logic [3:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             halted,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       dec_cls;
  logic             s1_valid;
  logic [3:0]       s1_cls;
  logic [CNT_W-1:0] cnt      [NUM_COUNTERS];
  logic [CNT_W-1:0] cnt_next [NUM_COUNTERS];
  logic             hit_max;
  logic             syscall_retire;

  // Register/immediate fields between op and funct do not affect the class.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[25:6];

  inst_classifier u_classifier (
    .op    (inst[31:26]),
    .funct (inst[5:0]),
    .cls   (dec_cls)
  );

  assign syscall_retire = HALT_ON_SYSCALL && s1_valid && (s1_cls == CLS_SYSCALL);

  // Stage 1: capture the decoded class unless capture is frozen or being cleared
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1_valid <= 1'b0;
      s1_cls   <= CLS_UNKNOWN;
    end else begin
      s1_valid <= inst_valid && !halted;
      s1_cls   <= dec_cls;
    end
  end

  // Saturating increment of the staged class counter and TOTAL; flags reaching all-ones
  always_comb begin
    hit_max = 1'b0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      cnt_next[i] = cnt[i];
      if (s1_valid && ((4'(i) == s1_cls) || (4'(i) == CLS_TOTAL)) && (cnt[i] != CNT_MAX)) begin
        cnt_next[i] = cnt[i] + CNT_ONE;
        if (cnt[i] == CNT_MAX - CNT_ONE) begin
          hit_max = 1'b1;
        end
      end
    end
  end

  // Stage 2: commit counter updates; clear drops any same-cycle increment
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (rst || clr) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // Halt goes high on the edge a SYSCALL is counted and holds until clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      halted <= 1'b0;
    end else if (syscall_retire) begin
      halted <= 1'b1;
    end
  end

  // Sticky saturation flag
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sat <= 1'b0;
    end else if (hit_max) begin
      sat <= 1'b1;
    end
  end

  // Registered readback of pre-update counter state; clear does not touch it directly
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_sel <= CLS_TOTAL) begin
      rd_data <= cnt[rd_sel];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
